async_fifo_rd_ctrl: RTL and testbench

ASYNC_FIFO_RD_CTRL -- requirements
Module: async_fifo_rd_ctrl

---
 rtl/async_fifo_rd_ctrl.sv | 126 ++++++++++++
 tb/tb_async_fifo_rd_ctrl.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/async_fifo_rd_ctrl.sv
// Read-side controller of an asynchronous FIFO: Gray read pointer, empty flag, and a
// two-entry (output + skid) stream buffer. Define ASYNC_FIFO_RLEVEL_EN to get rlevel/ralmost_empty.
module async_fifo_rd_ctrl #(
    parameter int ASIZE         = 4,
    parameter int DSIZE         = 8,
    parameter int AEMPTY_THRESH = 2
) (
    input  logic             rclk,
    input  logic             rrst_n,
    input  logic [ASIZE:0]   rq2_wptr,
    output logic [ASIZE:0]   rptr,
    output logic [ASIZE-1:0] raddr,
    output logic             ren,
    input  logic [DSIZE-1:0] rdata_mem,
    output logic [DSIZE-1:0] m_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic             rempty,
    output logic [ASIZE:0]   rlevel,
    output logic             ralmost_empty
);

    logic [ASIZE:0]   rbin_q, rbin_d, rptr_q, rgray_d;
    logic             rempty_q;
    logic [1:0]       occ_q, occ_d;
    logic             fetch_q;
    logic [DSIZE-1:0] mdata_q, mdata_d, skid_q, skid_d;
    logic             mvalid_q, mvalid_d, skid_valid_q, skid_valid_d;
    logic             pop;

    // Stream handshake: a word transfers on every rclk edge where m_valid && m_ready;
    // m_data/m_valid never change while m_valid is high and m_ready is low.
    assign pop     = mvalid_q && m_ready;
    // occ counts held words plus the fetch in flight, so two credits cover both entries.
    assign ren     = !rempty_q && ((occ_q != 2'd2) || pop);
    assign rbin_d  = rbin_q + (ASIZE+1)'(ren);
    assign rgray_d = rbin_d ^ (rbin_d >> 1);
    assign occ_d   = occ_q + 2'(ren) - 2'(pop);

    always_comb begin
        mdata_d      = mdata_q;
        mvalid_d     = mvalid_q;
        skid_d       = skid_q;
        skid_valid_d = skid_valid_q;
        if (pop) begin
            if (skid_valid_q) begin
                mdata_d      = skid_q;
                skid_valid_d = fetch_q;
                if (fetch_q) skid_d = rdata_mem;
            end else begin
                mvalid_d = fetch_q;
                if (fetch_q) mdata_d = rdata_mem;
            end
        end else if (fetch_q) begin
            if (!mvalid_q) begin
                mdata_d  = rdata_mem;
                mvalid_d = 1'b1;
            end else begin
                skid_d       = rdata_mem;
                skid_valid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            rbin_q       <= '0;
            rptr_q       <= '0;
            rempty_q     <= 1'b1;
            occ_q        <= 2'd0;
            fetch_q      <= 1'b0;
            mdata_q      <= '0;
            mvalid_q     <= 1'b0;
            skid_q       <= '0;
            skid_valid_q <= 1'b0;
        end else begin
            rbin_q       <= rbin_d;
            rptr_q       <= rgray_d;
            rempty_q     <= (rgray_d == rq2_wptr);
            occ_q        <= occ_d;
            fetch_q      <= ren;
            mdata_q      <= mdata_d;
            mvalid_q     <= mvalid_d;
            skid_q       <= skid_d;
            skid_valid_q <= skid_valid_d;
        end
    end

    assign raddr   = rbin_q[ASIZE-1:0];
    assign rptr    = rptr_q;
    assign rempty  = rempty_q;
    assign m_data  = mdata_q;
    assign m_valid = mvalid_q;

`ifdef ASYNC_FIFO_RLEVEL_EN
    function automatic logic [ASIZE:0] gray2bin(input logic [ASIZE:0] g);
        logic [ASIZE:0] b;
        b[ASIZE] = g[ASIZE];
        for (int i = ASIZE - 1; i >= 0; i--) b[i] = b[i+1] ^ g[i];
        return b;
    endfunction

    logic [ASIZE:0] level_d, rlevel_q;
    logic           ralmost_q;

    // Level is measured against the post-read pointer so it tracks this cycle's fetch.
    assign level_d = gray2bin(rq2_wptr) - rbin_d;

    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            rlevel_q  <= '0;
            ralmost_q <= 1'b1;
        end else begin
            rlevel_q  <= level_d;
            ralmost_q <= (level_d <= (ASIZE+1)'(AEMPTY_THRESH));
        end
    end

    assign rlevel        = rlevel_q;
    assign ralmost_empty = ralmost_q;
`else
    assign rlevel        = '0;
    assign ralmost_empty = 1'b0;
`endif

endmodule

// File: tb/tb_async_fifo_rd_ctrl.sv
// Directed bench for async_fifo_rd_ctrl: vector table for the first transfers, then
// back-pressure, wrap-around, mid-operation reset and level sequences.
module tb_async_fifo_rd_ctrl;
    localparam int ASIZE = 4;
    localparam int DSIZE = 8;
    localparam int AEMPTY_THRESH = 2;
`ifdef ASYNC_FIFO_RLEVEL_EN
    localparam logic EXP_AE_RST = 1'b1;
`else
    localparam logic EXP_AE_RST = 1'b0;
`endif

    logic             rclk = 1'b0;
    logic             rrst_n = 1'b0;
    logic [ASIZE:0]   rq2_wptr = '0;
    logic [ASIZE:0]   rptr;
    logic [ASIZE-1:0] raddr;
    logic             ren;
    logic [DSIZE-1:0] rdata_mem = '0;
    logic [DSIZE-1:0] m_data;
    logic             m_valid;
    logic             m_ready = 1'b0;
    logic             rempty;
    logic [ASIZE:0]   rlevel;
    logic             ralmost_empty;

    always #5 rclk = ~rclk;

    async_fifo_rd_ctrl #(.ASIZE(ASIZE), .DSIZE(DSIZE), .AEMPTY_THRESH(AEMPTY_THRESH)) dut (
        .rclk(rclk), .rrst_n(rrst_n), .rq2_wptr(rq2_wptr), .rptr(rptr), .raddr(raddr),
        .ren(ren), .rdata_mem(rdata_mem), .m_data(m_data), .m_valid(m_valid),
        .m_ready(m_ready), .rempty(rempty), .rlevel(rlevel), .ralmost_empty(ralmost_empty)
    );

    logic [DSIZE-1:0] mem [1 << ASIZE];
    always @(posedge rclk) if (ren) rdata_mem <= mem[raddr];

    int n_checks = 0;
    int n_pass = 0;
    int seq = 0;
    int pop_cnt = 0;
    int ren_cnt = 0;
    logic [ASIZE:0] wbin = '0;
    logic [ASIZE:0] rptr_prev = '0;
    logic [DSIZE-1:0] exp_q[$];

    function automatic logic [ASIZE:0] to_gray(input logic [ASIZE:0] b);
        return b ^ (b >> 1);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic write_words(input int n);
        logic [DSIZE-1:0] v;
        for (int i = 0; i < n; i++) begin
            v = DSIZE'(32'hA0 + seq);
            mem[wbin[ASIZE-1:0]] = v;
            exp_q.push_back(v);
            seq++;
            wbin++;
        end
        rq2_wptr = to_gray(wbin);
    endtask

    // Scoreboard and protocol monitor, sampled mid-cycle.
    always @(negedge rclk) begin
        if (rrst_n) begin
            check("ren_while_empty", {31'b0, ren && rempty}, 0);
            check("rptr_gray_step", {31'b0, $countones(rptr ^ rptr_prev) <= 1}, 1);
            rptr_prev <= rptr;
            if (ren) ren_cnt <= ren_cnt + 1;
            if (m_valid && m_ready) begin
                pop_cnt <= pop_cnt + 1;
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL sb_extra_word: got %0h expected no word", m_data);
                end else begin
                    check("sb_data", m_data, exp_q.pop_front());
                end
            end
        end else begin
            rptr_prev <= '0;
        end
    end

    typedef struct {
        int               n_wr;
        logic             rdy;
        logic             e_rempty;
        logic             e_ren;
        logic             e_valid;
        logic [DSIZE-1:0] e_data;
        logic [ASIZE-1:0] e_raddr;
        logic [ASIZE:0]   e_rptr;
    } vec_t;

    vec_t vt[12];

    initial begin
        int rc0, p0, target, cyc;
        vt[0]  = '{0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 4'd0, 5'd0};
        vt[1]  = '{1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 4'd0, 5'd0};
        vt[2]  = '{0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 4'd0, 5'd0};
        vt[3]  = '{0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 4'd1, 5'd1};
        vt[4]  = '{0, 1'b1, 1'b1, 1'b0, 1'b1, 8'hA0, 4'd1, 5'd1};
        vt[5]  = '{2, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 4'd1, 5'd1};
        vt[6]  = '{0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 4'd1, 5'd1};
        vt[7]  = '{0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 4'd2, 5'd3};
        vt[8]  = '{0, 1'b0, 1'b1, 1'b0, 1'b1, 8'hA1, 4'd3, 5'd2};
        vt[9]  = '{0, 1'b1, 1'b1, 1'b0, 1'b1, 8'hA1, 4'd3, 5'd2};
        vt[10] = '{0, 1'b1, 1'b1, 1'b0, 1'b1, 8'hA2, 4'd3, 5'd2};
        vt[11] = '{0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 4'd3, 5'd2};

        // Idle after reset with nothing written.
        repeat (3) @(posedge rclk);
        #1 rrst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge rclk);
            check("idle_rempty", {31'b0, rempty}, 1);
            check("idle_ren", {31'b0, ren}, 0);
            check("idle_m_valid", {31'b0, m_valid}, 0);
            check("idle_rptr", rptr, 0);
            check("idle_raddr", raddr, 0);
        end
        check("idle_rlevel", rlevel, 0);
        check("idle_ralmost_empty", {31'b0, ralmost_empty}, {31'b0, EXP_AE_RST});

        // First words: latency, empty re-assertion and skid use.
        for (int i = 0; i < 12; i++) begin
            @(posedge rclk);
            #1;
            m_ready = vt[i].rdy;
            write_words(vt[i].n_wr);
            @(negedge rclk);
            check($sformatf("vec%0d_rempty", i), {31'b0, rempty}, {31'b0, vt[i].e_rempty});
            check($sformatf("vec%0d_ren", i), {31'b0, ren}, {31'b0, vt[i].e_ren});
            check($sformatf("vec%0d_m_valid", i), {31'b0, m_valid}, {31'b0, vt[i].e_valid});
            check($sformatf("vec%0d_raddr", i), raddr, vt[i].e_raddr);
            check($sformatf("vec%0d_rptr", i), rptr, vt[i].e_rptr);
            if (vt[i].e_valid) check($sformatf("vec%0d_m_data", i), m_data, vt[i].e_data);
        end

        // Full FIFO under back-pressure, then full-rate drain.
        @(posedge rclk);
        #1 m_ready = 1'b0;
        rc0 = ren_cnt;
        write_words(16);
        repeat (8) @(posedge rclk);
        @(negedge rclk);
        check("bp_ren_pulses", ren_cnt - rc0, 2);
        check("bp_m_valid", {31'b0, m_valid}, 1);
        check("bp_m_data", m_data, 8'hA3);
        @(posedge rclk);
        #1 m_ready = 1'b1;
        p0 = pop_cnt;
        repeat (16) @(posedge rclk);
        #1;
        check("drain_pops_16_cycles", pop_cnt - p0, 16);
        check("drain_queue_empty", exp_q.size(), 0);
        @(negedge rclk);
        check("drain_m_valid_low", {31'b0, m_valid}, 0);

        // Random ready and write pacing across 7 pointer wraps.
        target = seq + 224;
        cyc = 0;
        while ((seq < target || exp_q.size() != 0) && cyc < 4000) begin
            @(posedge rclk);
            #1;
            cyc++;
            m_ready = 1'($urandom_range(0, 1));
            if (seq < target && (seq - pop_cnt) < 16 && $urandom_range(0, 3) != 0) write_words(1);
        end
        check("rand_all_written", seq, target);
        check("rand_queue_empty", exp_q.size(), 0);
        check("rand_pop_total", pop_cnt, seq);

        // Reset while both entries are full.
        @(posedge rclk);
        #1 m_ready = 1'b0;
        write_words(4);
        repeat (5) @(posedge rclk);
        @(negedge rclk);
        check("pre_rst_m_valid", {31'b0, m_valid}, 1);
        check("pre_rst_ren_held", {31'b0, ren}, 0);
        @(posedge rclk);
        #1 rrst_n = 1'b0;
        #1;
        check("rst_rempty", {31'b0, rempty}, 1);
        check("rst_ren", {31'b0, ren}, 0);
        check("rst_m_valid", {31'b0, m_valid}, 0);
        check("rst_m_data", m_data, 0);
        check("rst_rptr", rptr, 0);
        check("rst_raddr", raddr, 0);
        check("rst_rlevel", rlevel, 0);
        check("rst_ralmost_empty", {31'b0, ralmost_empty}, {31'b0, EXP_AE_RST});
        wbin = '0;
        rq2_wptr = '0;
        exp_q.delete();
        repeat (2) @(posedge rclk);
        #1 rrst_n = 1'b1;

        // Restart after reset, with level tracking.
        @(posedge rclk);
        #1 m_ready = 1'b1;
        write_words(5);
        @(negedge rclk);
        check("post_rst_no_ren_yet", {31'b0, ren}, 0);
        @(posedge rclk);
        @(negedge rclk);
        check("post_rst_first_ren", {31'b0, ren}, 1);
        check("post_rst_first_raddr", raddr, 0);
`ifdef ASYNC_FIFO_RLEVEL_EN
        check("level5", rlevel, 5);
        check("level5_almost", {31'b0, ralmost_empty}, 0);
`else
        check("level_tied", rlevel, 0);
        check("almost_tied", {31'b0, ralmost_empty}, 0);
`endif
        repeat (3) @(posedge rclk);
        @(negedge rclk);
`ifdef ASYNC_FIFO_RLEVEL_EN
        check("level2", rlevel, 2);
        check("level2_almost", {31'b0, ralmost_empty}, 1);
`else
        check("level_tied_late", rlevel, 0);
        check("almost_tied_late", {31'b0, ralmost_empty}, 0);
`endif
        repeat (20) @(posedge rclk);
        @(negedge rclk);
        check("final_queue_empty", exp_q.size(), 0);
        check("final_m_valid", {31'b0, m_valid}, 0);
        check("final_rempty", {31'b0, rempty}, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: got no finish expected finish before 500000");
        $fatal(1, "timeout");
    end

endmodule
